// File: rtl/booth_seq_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_seq_mul: iterative radix-4 Booth multiplier, one digit per clock. Rev 1.0
// ---------------------------------------------------------------------------
module booth_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  mcand;
  logic [EW-1:0]  mplier;
  logic           prev_bit;
  logic [CW-1:0]  count;

  logic [EW-1:0]  x_ext;
  logic [EW-1:0]  y_ext;
  logic [AW-1:0]  term;
  logic [AW-1:0]  acc_sum;
  logic [2:0]     digit;
  logic           accept;
  logic           last_digit;

  // Two extra bits make unsigned operands representable as positive signed values.
  assign x_ext      = {{2{signed_mode & x[WIDTH-1]}}, x};
  assign y_ext      = {{2{signed_mode & y[WIDTH-1]}}, y};
  assign digit      = {mplier[1:0], prev_bit};
  assign accept     = start && (state == S_IDLE || state == S_DONE);
  assign last_digit = (count == CW'(N - 1));
  assign acc_sum    = acc + term;

  always_comb begin
    term = '0;
    case (digit)
      3'b001, 3'b010: term = mcand;
      3'b011:         term = {mcand[AW-2:0], 1'b0};
      3'b100:         term = AW'(0) - {mcand[AW-2:0], 1'b0};
      3'b101, 3'b110: term = AW'(0) - mcand;
      default:        term = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_digit) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = start ? S_RUN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Multiplicand shifts up and multiplier shifts down so the digit is always in the low bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prev_bit <= 1'b0;
      count    <= '0;
      product  <= '0;
    end else if (accept) begin
      acc      <= '0;
      mcand    <= {{(AW-EW){x_ext[EW-1]}}, x_ext};
      mplier   <= y_ext;
      prev_bit <= 1'b0;
      count    <= '0;
    end else if (state == S_RUN) begin
      acc      <= acc_sum;
      mcand    <= {mcand[AW-3:0], 2'b00};
      mplier   <= {2'b00, mplier[EW-1:2]};
      prev_bit <= mplier[1];
      count    <= count + CW'(1);
      if (last_digit) product <= acc_sum[2*WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire
